// File: rtl/keypad_row_scanner.sv
// keypad_row_scanner: walks an active-low row across a keypad matrix and debounces full-scan results
module keypad_row_scanner #(
    parameter  int NROWS    = 4,
    parameter  int NCOLS    = 4,
    parameter  int SETTLE   = 7,
    parameter  int DEBOUNCE = 3,
    localparam int CW       = $clog2(NROWS * NCOLS),
    localparam int CW_R     = $clog2(NROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [NCOLS-1:0] col_in,
    output logic [NROWS-1:0] row_driver,
    output logic [CW_R-1:0]  row_sel,
    output logic             key_valid,
    output logic [CW-1:0]    key_code,
    output logic             key_held,
    output logic             multi_key
);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE} state_t;
    typedef enum logic [1:0] {R_NONE, R_SINGLE, R_MULTI} res_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [CW_R-1:0]  row_q, row_d;
    logic [NROWS-1:0] drv_q, drv_d;
    logic [1:0]       acc_n_q, acc_n_d;
    logic [CW-1:0]    acc_code_q, acc_code_d;
    logic [DW-1:0]    cnt_q, cnt_d;
    res_t             prev_q, prev_d;
    logic [CW-1:0]    pcode_q, pcode_d;
    logic [CW-1:0]    code_q, code_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic             multi_q, multi_d;
    logic             lock_q, lock_d;
    logic [1:0]       samp_n, tot_n;
    logic [2:0]       sum_n;
    logic [CW-1:0]    samp_code, tot_code;
    res_t             res;
    logic             same, stable;

    // Closed keys on the driven row, merged with what this scan has already seen (count saturates at 2)
    always_comb begin
        samp_n    = '0;
        samp_code = '0;
        for (int i = 0; i < NCOLS; i++) begin
            if (!col_in[i]) begin
                samp_n    = (samp_n == 2'd0) ? 2'd1 : 2'd2;
                samp_code = CW'(row_q) * CW'(NCOLS) + CW'(i);
            end
        end
        sum_n    = {1'b0, acc_n_q} + {1'b0, samp_n};
        tot_n    = (sum_n > 3'd2) ? 2'd2 : sum_n[1:0];
        tot_code = (acc_n_q != 2'd0) ? acc_code_q : samp_code;
        res      = (tot_n == 2'd0) ? R_NONE : (tot_n == 2'd1) ? R_SINGLE : R_MULTI;
        same     = (res == prev_q) && (res != R_SINGLE || tot_code == pcode_q);
    end

    // Row walk, per-scan accumulation, and the debounce decision taken at the wrap of the last row;
    // a debounced MULTI locks out acceptance until a debounced NONE is seen
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        row_d      = row_q;
        acc_n_d    = acc_n_q;
        acc_code_d = acc_code_q;
        cnt_d      = cnt_q;
        prev_d     = prev_q;
        pcode_d    = pcode_q;
        code_d     = code_q;
        valid_d    = 1'b0;
        held_d     = held_q;
        multi_d    = multi_q;
        lock_d     = lock_q;
        stable     = 1'b0;
        if (!enable) begin
            state_d    = IDLE;
            settle_d   = '0;
            row_d      = '0;
            acc_n_d    = '0;
            acc_code_d = '0;
            cnt_d      = '0;
            prev_d     = R_NONE;
            pcode_d    = '0;
            held_d     = 1'b0;
            multi_d    = 1'b0;
            lock_d     = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = DRIVE;
        end else if (state_q == DRIVE) begin
            state_d  = (settle_q == SW'(SETTLE - 1)) ? SAMPLE : DRIVE;
            settle_d = (settle_q == SW'(SETTLE - 1)) ? '0 : settle_q + 1'b1;
        end else begin
            state_d = DRIVE;
            if (row_q == CW_R'(NROWS - 1)) begin
                row_d      = '0;
                acc_n_d    = '0;
                acc_code_d = '0;
                cnt_d      = !same ? DW'(1) : (cnt_q == DW'(DEBOUNCE)) ? cnt_q : cnt_q + 1'b1;
                prev_d     = res;
                pcode_d    = tot_code;
                stable     = (cnt_d == DW'(DEBOUNCE));
                multi_d    = stable && res == R_MULTI;
                valid_d    = stable && res == R_SINGLE && !held_q && !lock_q;
                code_d     = valid_d ? tot_code : code_q;
                held_d     = valid_d || (held_q && !(stable && res == R_NONE));
                lock_d     = (stable && res == R_MULTI) || (lock_q && !(stable && res == R_NONE));
            end else begin
                row_d      = row_q + 1'b1;
                acc_n_d    = tot_n;
                acc_code_d = tot_code;
            end
        end
    end

    assign drv_d = (state_d == IDLE) ? '0 : (NROWS'(1) << row_d);

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            settle_q   <= '0;
            row_q      <= '0;
            drv_q      <= '0;
            acc_n_q    <= '0;
            acc_code_q <= '0;
            cnt_q      <= '0;
            prev_q     <= R_NONE;
            pcode_q    <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
            multi_q    <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            row_q      <= row_d;
            drv_q      <= drv_d;
            acc_n_q    <= acc_n_d;
            acc_code_q <= acc_code_d;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            pcode_q    <= pcode_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            held_q     <= held_d;
            multi_q    <= multi_d;
            lock_q     <= lock_d;
        end
    end

    assign row_sel   = row_q;
    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign key_held  = held_q;
    assign multi_key = multi_q;

    for (genvar r = 0; r < NROWS; r++) begin : g_row
        assign row_driver[r] = drv_q[r] ? 1'b0 : 1'bz;
    end
endmodule

// File: tb/tb_keypad_row_scanner.sv
// tb_keypad_row_scanner: randomized keypad stimulus against a scan-level debounce model
module tb_keypad_row_scanner;
    localparam int NR   = 4;
    localparam int NC   = 4;
    localparam int ST   = 7;
    localparam int DB   = 3;
    localparam int NK   = NR * NC;
    localparam int SCAN = NR * (ST + 1);

    typedef struct {
        int due;
        bit strobe;
        int code;
        bit held;
        bit multi;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [NC-1:0] col_in;
    wire  [NR-1:0] row_driver;
    logic [1:0]    row_sel;
    logic          key_valid;
    logic [3:0]    key_code;
    logic          key_held;
    logic          multi_key;
    logic [NK-1:0] pressed = '0;
    logic [NC-1:0] noise = '0;
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    bit            running = 1'b0;
    exp_t          sb[$];
    exp_t          mon_e;
    int            hist[$];
    bit            m_held = 1'b0;
    bit            m_lock = 1'b0;
    int            m_code = 0;

    keypad_row_scanner dut (
        .clk(clk), .reset(reset), .enable(enable), .col_in(col_in),
        .row_driver(row_driver), .row_sel(row_sel), .key_valid(key_valid),
        .key_code(key_code), .key_held(key_held), .multi_key(multi_key)
    );

    for (genvar g = 0; g < NR; g++) begin : g_pu
        pullup pu (row_driver[g]);
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Physical keypad: a closed key pulls its column low while its row is selected; noise is glitching
    always_comb begin
        col_in = '1;
        for (int c = 0; c < NC; c++) col_in[c] = ~pressed[int'(row_sel) * NC + c] ^ noise[c];
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    // Scan-level model: result is NONE(-1), MULTI(-2) or the key index; debounce = last DB results equal
    task automatic model_scan(input logic [NK-1:0] p, input int due);
        exp_t e;
        int v, n;
        bit stable;
        n = 0;
        v = -1;
        for (int i = 0; i < NK; i++) if (p[i]) begin n++; v = i; end
        if (n > 1) v = -2;
        hist.push_back(v);
        if (hist.size() > DB) void'(hist.pop_front());
        stable = (hist.size() == DB);
        foreach (hist[i]) if (hist[i] != v) stable = 1'b0;
        e.strobe = stable && v >= 0 && !m_held && !m_lock;
        if (e.strobe) begin m_held = 1'b1; m_code = v; end
        if (stable && v == -1) begin m_held = 1'b0; m_lock = 1'b0; end
        if (stable && v == -2) m_lock = 1'b1;
        e.due   = due;
        e.code  = m_code;
        e.held  = m_held;
        e.multi = stable && v == -2;
        sb.push_back(e);
    endtask

    // Entered on the negedge in cycle 0 of a scan; leaves on cycle 0 of the next scan
    task automatic run_scan(input logic [NK-1:0] p, input bit glitch);
        logic [NR-1:0] exp_rd;
        pressed = p;
        model_scan(p, cyc + SCAN);
        for (int k = 0; k < SCAN; k++) begin
            if (k % (ST + 1) == 0) begin
                exp_rd = ~(NR'(1) << (k / (ST + 1)));
                check("row_sel", int'(row_sel), k / (ST + 1));
                check("row_driver", int'(row_driver), int'(exp_rd));
            end
            noise = (glitch && (k % (ST + 1)) != ST) ? NC'($urandom) : '0;
            @(negedge clk);
        end
        noise = '0;
    endtask

    // Interrupts the scan in row 2's DRIVE slot by dropping enable or pulsing reset, then restarts
    task automatic abort_scan(input logic [NK-1:0] p, input bit use_reset);
        pressed = p;
        noise = '0;
        repeat (2 * (ST + 1) + 3) @(negedge clk);
        check("abort_row", int'(row_sel), 2);
        if (use_reset) reset = 1'b1;
        else enable = 1'b0;
        @(negedge clk);
        hist.delete();
        m_held = 1'b0;
        m_lock = 1'b0;
        if (use_reset) m_code = 0;
        check("abort_rows_z", int'(row_driver), (1 << NR) - 1);
        check("abort_row_sel", int'(row_sel), 0);
        check("abort_held", int'(key_held), 0);
        check("abort_multi", int'(multi_key), 0);
        check("abort_code", int'(key_code), m_code);
        reset = 1'b0;
        enable = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: compare scoreboard entries when due, and flag any strobe nobody expected
    always @(negedge clk) begin
        if (running) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                check("key_valid", int'(key_valid), int'(mon_e.strobe));
                check("key_code", int'(key_code), mon_e.code);
                check("key_held", int'(key_held), int'(mon_e.held));
                check("multi_key", int'(multi_key), int'(mon_e.multi));
            end else begin
                check("stray_strobe", int'(key_valid), 0);
            end
        end
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [NK-1:0] p;
        int n, k;
        reset = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_rows_z", int'(row_driver), (1 << NR) - 1);
        check("rst_valid", int'(key_valid), 0);
        check("rst_code", int'(key_code), 0);
        check("rst_held", int'(key_held), 0);
        check("rst_multi", int'(multi_key), 0);
        reset = 1'b0;
        running = 1'b1;
        @(negedge clk);
        // single key (2,1)
        repeat (5) run_scan(NK'(1) << 9, 1'b0);
        // release, then bouncing key (1,3) before settling
        repeat (3) run_scan('0, 1'b0);
        for (int i = 0; i < 4; i++) run_scan((i % 2 == 0) ? NK'(1) << 7 : '0, 1'b0);
        repeat (4) run_scan(NK'(1) << 7, 1'b1);
        // multi: (0,0)+(3,2), then (0,0) alone, release, (0,0) again
        repeat (3) run_scan('0, 1'b0);
        repeat (4) run_scan((NK'(1) << 0) | (NK'(1) << 14), 1'b0);
        repeat (4) run_scan(NK'(1) << 0, 1'b0);
        repeat (3) run_scan('0, 1'b0);
        repeat (4) run_scan(NK'(1) << 0, 1'b0);
        // release and repress (3,3)
        repeat (3) run_scan('0, 1'b0);
        repeat (4) run_scan(NK'(1) << 15, 1'b0);
        repeat (3) run_scan('0, 1'b0);
        repeat (4) run_scan(NK'(1) << 15, 1'b1);
        // aborts by enable and by reset
        repeat (2) run_scan(NK'(1) << 5, 1'b0);
        abort_scan(NK'(1) << 5, 1'b0);
        repeat (4) run_scan(NK'(1) << 5, 1'b0);
        repeat (2) run_scan(NK'(1) << 6, 1'b0);
        abort_scan(NK'(1) << 6, 1'b1);
        repeat (4) run_scan(NK'(1) << 6, 1'b0);
        // random pattern runs
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(9);
            p = '0;
            k = $urandom_range(NK - 1);
            if (n >= 3) p[k] = 1'b1;
            if (n >= 8) p[(k + 1 + $urandom_range(NK - 2)) % NK] = 1'b1;
            if ($urandom_range(9) == 0) abort_scan(p, $urandom_range(1) == 1);
            repeat ($urandom_range(5, 1)) run_scan(p, $urandom_range(1) == 1);
        end
        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
